// File: rtl/rs_pkg.sv
`default_nettype none
//-----------------------------------------------------------------------------
//  Module  : rs_pkg
//  Purpose : Shared types for the reservation-station dispatch controller:
//            entry record, dispatch FSM states and the "operand present" tag.
//            The entry record is sized by RS_DATA_W / RS_TAG_W; instantiating
//            modules must use matching DATA_W / TAG_W.
//  Rev     : 1.0  initial release
//-----------------------------------------------------------------------------
package rs_pkg;

   localparam int RS_INSTR_W = 16;
   localparam int RS_DATA_W  = 16;
   localparam int RS_TAG_W   = 3;

   // A Q field equal to this tag means the matching V field holds the value.
   localparam logic [RS_TAG_W-1:0] TAG_NONE = '0;

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_WAIT = 1'b1
   } rs_state_t;

   typedef struct packed {
      logic                  valid;
      logic [RS_INSTR_W-1:0] instr;
      logic [RS_TAG_W-1:0]   tag;
      logic [RS_DATA_W-1:0]  vj;
      logic [RS_DATA_W-1:0]  vk;
      logic [RS_TAG_W-1:0]   qj;
      logic [RS_TAG_W-1:0]   qk;
   } rs_entry_t;

   // Entry holds an instruction whose operands are both present.
   function automatic logic entry_ready(input rs_entry_t e);
      return e.valid && (e.qj == TAG_NONE) && (e.qk == TAG_NONE);
   endfunction

endpackage
`default_nettype wire

// File: rtl/rs_rr_picker.sv
`default_nettype none
//-----------------------------------------------------------------------------
//  Module  : rs_rr_picker
//  Purpose : Round-robin selector. Scans the request vector starting at
//            i_ptr and wrapping, returns the first requesting index.
//  Ports   : i_req    N-bit request vector
//            i_ptr    index where the scan starts
//            o_grant  selected index (0 when nothing requests)
//            o_any    at least one request present
//  Rev     : 1.0  initial release
//-----------------------------------------------------------------------------
module rs_rr_picker #(
   parameter int N = 4
) (
   input  logic [N-1:0]         i_req,
   input  logic [$clog2(N)-1:0] i_ptr,
   output logic [$clog2(N)-1:0] o_grant,
   output logic                 o_any
);

   localparam int IDX_W = $clog2(N);

   int               w_idx;
   logic [IDX_W-1:0] w_sel;

   // Walk offsets from the far end back to 0 so the nearest request to
   // i_ptr is the last one written and therefore wins.
   always_comb begin
      o_any   = 1'b0;
      o_grant = '0;
      w_idx   = 0;
      w_sel   = '0;
      for (int off = N - 1; off >= 0; off--) begin
         w_idx = (int'(i_ptr) + off) % N;
         w_sel = IDX_W'(w_idx);
         if (i_req[w_sel]) begin
            o_any   = 1'b1;
            o_grant = w_sel;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/rs_dispatch_ctrl.sv
`default_nettype none
//-----------------------------------------------------------------------------
//  Module  : rs_dispatch_ctrl
//  Purpose : Reservation station for one functional unit. Holds up to DEPTH
//            issued instructions, snoops the CDB for missing operands and
//            dispatches one operand-complete entry at a time to the FU over
//            a start/done handshake (round-robin between ready entries).
//  Ports   : clock, reset_n            clock / async active-low reset
//            issue_*                   instruction from issue stage
//            issue_ready               a free entry exists
//            cdb_valid/tag/data        result broadcast
//            fu_start                  one-cycle dispatch pulse
//            fu_instr/tag/a/b          registered dispatch payload
//            fu_done                   FU completion
//            occupancy                 number of valid entries
//  Rev     : 1.0  initial release
//-----------------------------------------------------------------------------
module rs_dispatch_ctrl
   import rs_pkg::*;
#(
   parameter int DEPTH  = 4,
   parameter int DATA_W = RS_DATA_W,
   parameter int TAG_W  = RS_TAG_W
) (
   input  logic                       clock,
   input  logic                       reset_n,
   input  logic                       issue_valid,
   output logic                       issue_ready,
   input  logic [15:0]                issue_instr,
   input  logic [TAG_W-1:0]           issue_tag,
   input  logic [DATA_W-1:0]          issue_vj,
   input  logic [DATA_W-1:0]          issue_vk,
   input  logic [TAG_W-1:0]           issue_qj,
   input  logic [TAG_W-1:0]           issue_qk,
   input  logic                       cdb_valid,
   input  logic [TAG_W-1:0]           cdb_tag,
   input  logic [DATA_W-1:0]          cdb_data,
   output logic                       fu_start,
   output logic [15:0]                fu_instr,
   output logic [TAG_W-1:0]           fu_tag,
   output logic [DATA_W-1:0]          fu_a,
   output logic [DATA_W-1:0]          fu_b,
   input  logic                       fu_done,
   output logic [$clog2(DEPTH+1)-1:0] occupancy
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam int OCC_W = $clog2(DEPTH + 1);

   rs_entry_t        r_ent [DEPTH];
   rs_state_t        r_state;
   logic [IDX_W-1:0] r_rr_ptr;
   logic [OCC_W-1:0] r_occ;
   logic             r_fu_start;
   logic [15:0]      r_fu_instr;
   logic [TAG_W-1:0] r_fu_tag;
   logic [DATA_W-1:0] r_fu_a;
   logic [DATA_W-1:0] r_fu_b;

   logic [DEPTH-1:0] w_ready;
   logic [IDX_W-1:0] w_gnt;
   logic             w_any;
   logic [IDX_W-1:0] w_free_idx;
   logic             w_issue;
   logic             w_dispatch;
   logic             w_cdb_hit;
   rs_entry_t        w_new_entry;

   // Readiness uses only registered entry state, so an operand captured
   // from the CDB on this edge becomes eligible on the next one.
   always_comb begin
      w_ready = '0;
      for (int i = 0; i < DEPTH; i++) begin
         w_ready[i] = entry_ready(r_ent[i]);
      end
   end

   rs_rr_picker #(
      .N       (DEPTH)
   ) u_picker (
      .i_req   (w_ready),
      .i_ptr   (r_rr_ptr),
      .o_grant (w_gnt),
      .o_any   (w_any)
   );

   // Lowest-index free slot. A slot being dispatched this edge still reads
   // as valid here, so it is never handed to a same-edge issue.
   always_comb begin
      w_free_idx = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (!r_ent[i].valid) begin
            w_free_idx = IDX_W'(i);
         end
      end
   end

   assign issue_ready = (r_occ != OCC_W'(DEPTH));
   assign w_issue     = issue_valid && issue_ready;
   assign w_dispatch  = (r_state == S_IDLE) && w_any;
   assign w_cdb_hit   = cdb_valid && (cdb_tag != TAG_NONE);

   // New entry, with operands forwarded from a same-cycle broadcast.
   always_comb begin
      w_new_entry       = '0;
      w_new_entry.valid = 1'b1;
      w_new_entry.instr = issue_instr;
      w_new_entry.tag   = issue_tag;
      w_new_entry.vj    = issue_vj;
      w_new_entry.vk    = issue_vk;
      w_new_entry.qj    = issue_qj;
      w_new_entry.qk    = issue_qk;
      if (w_cdb_hit && (issue_qj == cdb_tag)) begin
         w_new_entry.vj = cdb_data;
         w_new_entry.qj = TAG_NONE;
      end
      if (w_cdb_hit && (issue_qk == cdb_tag)) begin
         w_new_entry.vk = cdb_data;
         w_new_entry.qk = TAG_NONE;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_ent[i] <= '0;
         end
         r_state    <= S_IDLE;
         r_rr_ptr   <= '0;
         r_occ      <= '0;
         r_fu_start <= 1'b0;
         r_fu_instr <= '0;
         r_fu_tag   <= '0;
         r_fu_a     <= '0;
         r_fu_b     <= '0;
      end else begin
         // Operand capture from the CDB, j and k independently.
         for (int i = 0; i < DEPTH; i++) begin
            if (r_ent[i].valid && w_cdb_hit) begin
               if (r_ent[i].qj == cdb_tag) begin
                  r_ent[i].vj <= cdb_data;
                  r_ent[i].qj <= TAG_NONE;
               end
               if (r_ent[i].qk == cdb_tag) begin
                  r_ent[i].vk <= cdb_data;
                  r_ent[i].qk <= TAG_NONE;
               end
            end
         end

         case (r_state)
            S_IDLE: begin
               r_fu_start <= 1'b0;
               if (w_dispatch) begin
                  r_fu_instr          <= r_ent[w_gnt].instr;
                  r_fu_tag            <= r_ent[w_gnt].tag;
                  r_fu_a              <= r_ent[w_gnt].vj;
                  r_fu_b              <= r_ent[w_gnt].vk;
                  r_ent[w_gnt].valid  <= 1'b0;
                  r_rr_ptr            <= (w_gnt == IDX_W'(DEPTH - 1)) ? '0
                                                                      : w_gnt + IDX_W'(1);
                  r_fu_start          <= 1'b1;
                  r_state             <= S_WAIT;
               end
            end
            S_WAIT: begin
               r_fu_start <= 1'b0;
               if (fu_done) begin
                  r_state <= S_IDLE;
               end
            end
            default: begin
               r_fu_start <= 1'b0;
               r_state    <= S_IDLE;
            end
         endcase

         // The issue target is a currently invalid slot, so it never
         // collides with the capture or dispatch writes above.
         if (w_issue) begin
            r_ent[w_free_idx] <= w_new_entry;
         end

         r_occ <= r_occ + OCC_W'(w_issue) - OCC_W'(w_dispatch);
      end
   end

   assign fu_start  = r_fu_start;
   assign fu_instr  = r_fu_instr;
   assign fu_tag    = r_fu_tag;
   assign fu_a      = r_fu_a;
   assign fu_b      = r_fu_b;
   assign occupancy = r_occ;

endmodule
`default_nettype wire

// File: tb/tb_rs_dispatch_ctrl.sv
`default_nettype none
//-----------------------------------------------------------------------------
//  Module  : tb_rs_dispatch_ctrl
//  Purpose : Directed, self-checking bench for rs_dispatch_ctrl. Expected
//            dispatches are queued when stimulus is driven and compared when
//            fu_start is seen. A small FU model answers each start with a
//            done pulse, and can be held busy to let the station fill.
//  Rev     : 1.0  initial release
//-----------------------------------------------------------------------------
module tb_rs_dispatch_ctrl;

   typedef struct packed {
      logic [15:0] instr;
      logic [2:0]  tag;
      logic [15:0] a;
      logic [15:0] b;
   } exp_t;

   logic        clock;
   logic        reset_n;
   logic        issue_valid;
   logic        issue_ready;
   logic [15:0] issue_instr;
   logic [2:0]  issue_tag;
   logic [15:0] issue_vj;
   logic [15:0] issue_vk;
   logic [2:0]  issue_qj;
   logic [2:0]  issue_qk;
   logic        cdb_valid;
   logic [2:0]  cdb_tag;
   logic [15:0] cdb_data;
   logic        fu_start;
   logic [15:0] fu_instr;
   logic [2:0]  fu_tag;
   logic [15:0] fu_a;
   logic [15:0] fu_b;
   logic        fu_done;
   logic [2:0]  occupancy;

   logic        fu_hold;
   logic        fu_pend;

   exp_t        sb_q[$];
   exp_t        mon_e;
   int          n_chk;
   int          n_err;
   int          cyc;
   int          last_cyc;
   bit          have_last;
   int          c;

   rs_dispatch_ctrl #(
      .DEPTH       (4),
      .DATA_W      (16),
      .TAG_W       (3)
   ) dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .issue_valid (issue_valid),
      .issue_ready (issue_ready),
      .issue_instr (issue_instr),
      .issue_tag   (issue_tag),
      .issue_vj    (issue_vj),
      .issue_vk    (issue_vk),
      .issue_qj    (issue_qj),
      .issue_qk    (issue_qk),
      .cdb_valid   (cdb_valid),
      .cdb_tag     (cdb_tag),
      .cdb_data    (cdb_data),
      .fu_start    (fu_start),
      .fu_instr    (fu_instr),
      .fu_tag      (fu_tag),
      .fu_a        (fu_a),
      .fu_b        (fu_b),
      .fu_done     (fu_done),
      .occupancy   (occupancy)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // FU model: done one edge after start unless held busy.
   always @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         fu_done <= 1'b0;
         fu_pend <= 1'b0;
      end else if (fu_done) begin
         fu_done <= 1'b0;
      end else if ((fu_start || fu_pend) && !fu_hold) begin
         fu_done <= 1'b1;
         fu_pend <= 1'b0;
      end else if (fu_start) begin
         fu_pend <= 1'b1;
      end
   end

   task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
      end
   endtask

   task automatic set_issue(input logic [15:0] instr, input logic [2:0] tag,
                            input logic [15:0] vj, input logic [15:0] vk,
                            input logic [2:0] qj, input logic [2:0] qk);
      issue_valid = 1'b1;
      issue_instr = instr;
      issue_tag   = tag;
      issue_vj    = vj;
      issue_vk    = vk;
      issue_qj    = qj;
      issue_qk    = qk;
   endtask

   // Scoreboard side: every dispatch must match the head of the queue and
   // be at least three cycles after the previous one.
   always @(negedge clock) begin
      cyc++;
      if (reset_n && fu_start) begin
         check("sb_nonempty_at_dispatch", 32'(sb_q.size() != 0), 32'd1);
         if (sb_q.size() != 0) begin
            mon_e = sb_q.pop_front();
            check("fu_instr", 32'(fu_instr), 32'(mon_e.instr));
            check("fu_tag",   32'(fu_tag),   32'(mon_e.tag));
            check("fu_a",     32'(fu_a),     32'(mon_e.a));
            check("fu_b",     32'(fu_b),     32'(mon_e.b));
         end
         if (have_last) begin
            check("dispatch_gap_ge3", 32'((cyc - last_cyc) >= 3), 32'd1);
         end
         last_cyc  = cyc;
         have_last = 1'b1;
      end
   end

   initial begin
      n_chk = 0; n_err = 0; cyc = 0; last_cyc = 0; have_last = 1'b0;
      fu_hold = 1'b0;
      issue_valid = 1'b0; issue_instr = '0; issue_tag = '0;
      issue_vj = '0; issue_vk = '0; issue_qj = '0; issue_qk = '0;
      cdb_valid = 1'b0; cdb_tag = '0; cdb_data = '0;
      reset_n = 1'b0;
      repeat (3) @(negedge clock);
      check("rst_occupancy",   32'(occupancy),   32'd0);
      check("rst_issue_ready", 32'(issue_ready), 32'd1);
      check("rst_fu_start",    32'(fu_start),    32'd0);
      check("rst_fu_a",        32'(fu_a),        32'd0);
      check("rst_fu_tag",      32'(fu_tag),      32'd0);
      reset_n = 1'b1;
      @(negedge clock);

      // T1: ready instruction dispatches one edge after issue.
      set_issue(16'h0000, 3'd1, 16'd5, 16'd7, 3'd0, 3'd0);
      sb_q.push_back('{16'h0000, 3'd1, 16'd5, 16'd7});
      @(negedge clock);
      issue_valid = 1'b0;
      check("t1_occ_after_issue", 32'(occupancy), 32'd1);
      check("t1_no_start_yet",    32'(fu_start),  32'd0);
      @(negedge clock);
      check("t1_start",           32'(fu_start),  32'd1);
      check("t1_occ_after_disp",  32'(occupancy), 32'd0);
      repeat (4) @(negedge clock);
      check("t1_drained", 32'(sb_q.size()), 32'd0);

      // T2: pending j operand filled from CDB, eligible the edge after.
      set_issue(16'h0011, 3'd2, 16'd0, 16'd3, 3'd1, 3'd0);
      sb_q.push_back('{16'h0011, 3'd2, 16'd20, 16'd3});
      @(negedge clock);
      issue_valid = 1'b0;
      cdb_valid = 1'b1; cdb_tag = 3'd1; cdb_data = 16'd20;
      check("t2_waiting_operand", 32'(fu_start), 32'd0);
      @(negedge clock);
      cdb_valid = 1'b0;
      check("t2_not_same_edge", 32'(fu_start), 32'd0);
      @(negedge clock);
      check("t2_start", 32'(fu_start), 32'd1);
      repeat (4) @(negedge clock);
      check("t2_drained", 32'(sb_q.size()), 32'd0);

      // T3: CDB bypass on the issue edge, no extra wait.
      set_issue(16'h0022, 3'd4, 16'd1, 16'd0, 3'd0, 3'd3);
      cdb_valid = 1'b1; cdb_tag = 3'd3; cdb_data = 16'd9;
      sb_q.push_back('{16'h0022, 3'd4, 16'd1, 16'd9});
      @(negedge clock);
      issue_valid = 1'b0; cdb_valid = 1'b0;
      check("t3_issue_edge", 32'(fu_start), 32'd0);
      @(negedge clock);
      check("t3_bypass_no_wait", 32'(fu_start), 32'd1);
      repeat (4) @(negedge clock);
      check("t3_drained", 32'(sb_q.size()), 32'd0);

      // T4: FU held busy, station fills, fifth issue is refused.
      // X lands in slot 0 and dispatches (pointer -> 1); A,B,C,D then take
      // slots 1,0,2,3, so round-robin from 1 yields A,C,D,B.
      fu_hold = 1'b1;
      set_issue(16'h0030, 3'd5, 16'd10, 16'd11, 3'd0, 3'd0);
      sb_q.push_back('{16'h0030, 3'd5, 16'd10, 16'd11});
      @(negedge clock);
      set_issue(16'h0041, 3'd1, 16'h0041, 16'h0141, 3'd0, 3'd0);
      @(negedge clock);
      set_issue(16'h0042, 3'd2, 16'h0042, 16'h0142, 3'd0, 3'd0);
      @(negedge clock);
      set_issue(16'h0043, 3'd3, 16'h0043, 16'h0143, 3'd0, 3'd0);
      @(negedge clock);
      set_issue(16'h0044, 3'd4, 16'h0044, 16'h0144, 3'd0, 3'd0);
      @(negedge clock);
      check("t4_full_ready", 32'(issue_ready), 32'd0);
      check("t4_full_occ",   32'(occupancy),   32'd4);
      set_issue(16'h0055, 3'd6, 16'h0055, 16'h0155, 3'd0, 3'd0);
      @(negedge clock);
      issue_valid = 1'b0;
      check("t4_fifth_ignored_occ",   32'(occupancy),   32'd4);
      check("t4_fifth_ignored_ready", 32'(issue_ready), 32'd0);
      sb_q.push_back('{16'h0041, 3'd1, 16'h0041, 16'h0141});
      sb_q.push_back('{16'h0043, 3'd3, 16'h0043, 16'h0143});
      sb_q.push_back('{16'h0044, 3'd4, 16'h0044, 16'h0144});
      sb_q.push_back('{16'h0042, 3'd2, 16'h0042, 16'h0142});
      fu_hold = 1'b0;
      for (int k = 0; k < 4; k++) begin
         c = 0;
         do begin
            @(negedge clock);
            c++;
         end while (!fu_start && c < 12);
         check($sformatf("t4_start_%0d", k), 32'(fu_start),  32'd1);
         check($sformatf("t4_occ_%0d", k),   32'(occupancy), 32'(3 - k));
      end
      repeat (4) @(negedge clock);
      check("t4_drained", 32'(sb_q.size()), 32'd0);

      // T5: round-robin. P dispatches from slot 0 (pointer -> 1); Q waits
      // in slot 1 on tag 6; R and S ready in slots 0 and 2. Expect S, R, Q.
      fu_hold = 1'b1;
      set_issue(16'h0060, 3'd1, 16'h0060, 16'h0160, 3'd0, 3'd0);
      sb_q.push_back('{16'h0060, 3'd1, 16'h0060, 16'h0160});
      @(negedge clock);
      set_issue(16'h0061, 3'd2, 16'h0000, 16'd4, 3'd6, 3'd0);
      @(negedge clock);
      set_issue(16'h0062, 3'd3, 16'h0062, 16'h0162, 3'd0, 3'd0);
      @(negedge clock);
      set_issue(16'h0063, 3'd4, 16'h0063, 16'h0163, 3'd0, 3'd0);
      @(negedge clock);
      issue_valid = 1'b0;
      check("t5_occ", 32'(occupancy), 32'd3);
      sb_q.push_back('{16'h0063, 3'd4, 16'h0063, 16'h0163});
      sb_q.push_back('{16'h0062, 3'd3, 16'h0062, 16'h0162});
      fu_hold = 1'b0;
      c = 0;
      do begin
         @(negedge clock);
         c++;
      end while (!fu_start && c < 12);
      check("t5_start",        32'(fu_start), 32'd1);
      check("t5_rr_skips_to_2", 32'(fu_tag),  32'd4);
      cdb_valid = 1'b1; cdb_tag = 3'd6; cdb_data = 16'd33;
      sb_q.push_back('{16'h0061, 3'd2, 16'd33, 16'd4});
      @(negedge clock);
      cdb_valid = 1'b0;
      repeat (12) @(negedge clock);
      check("t5_drained", 32'(sb_q.size()), 32'd0);

      // T6: reset asserted while waiting on the FU with 3 entries queued.
      fu_hold = 1'b1;
      set_issue(16'h0070, 3'd1, 16'h0070, 16'h0170, 3'd0, 3'd0);
      sb_q.push_back('{16'h0070, 3'd1, 16'h0070, 16'h0170});
      @(negedge clock);
      set_issue(16'h0071, 3'd2, 16'h0071, 16'h0171, 3'd0, 3'd0);
      @(negedge clock);
      set_issue(16'h0072, 3'd3, 16'h0072, 16'h0172, 3'd0, 3'd0);
      @(negedge clock);
      set_issue(16'h0073, 3'd4, 16'h0073, 16'h0173, 3'd0, 3'd0);
      @(negedge clock);
      issue_valid = 1'b0;
      check("t6_occ_before_reset", 32'(occupancy), 32'd3);
      reset_n = 1'b0;
      #1;
      check("t6_rst_fu_start",    32'(fu_start),    32'd0);
      check("t6_rst_occupancy",   32'(occupancy),   32'd0);
      check("t6_rst_issue_ready", 32'(issue_ready), 32'd1);
      check("t6_rst_fu_a",        32'(fu_a),        32'd0);
      @(negedge clock);
      reset_n = 1'b1;
      fu_hold = 1'b0;
      repeat (10) @(negedge clock);
      check("t6_occ_after_release", 32'(occupancy), 32'd0);

      check("final_sb_empty", 32'(sb_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
`default_nettype wire
